// File: rtl/ej32_dc_seq.sv
// ej32_dc_seq - eJ32 decoder/sequencer with prefetch queue.
//
// Bytes from the memory bus enter a DEPTH-entry prefetch queue. The head
// byte is loaded as the current opcode; per-opcode behaviour (unit mask,
// mode, last phase index) comes from an external decode-table ROM addressed
// by code. The phase counter sequences the instruction until it retires.
//
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   dc_en           decoder enable (0 freezes sequencing; pushes still accepted)
//   ram_d, ram_vld  fetched byte and its valid strobe
//   fq_rdy          queue not full
//   flush           branch taken: drop queue and current instruction
//   code, dc_vld    current opcode and its valid flag
//   phase, opnd     phase counter and big-endian operand accumulator
//   tb_mask/mode/cnt decode-table ROM response for code
//   busy            per-unit busy lines
//   u_en            per-unit enables
//   p_inc           one byte consumed from the queue this cycle
//   stall           valid instruction neither retiring nor advancing
module ej32_dc_seq #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PH_W   = 3,
  parameter int unsigned N_UNIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dc_en,
  input  logic [7:0]        ram_d,
  input  logic              ram_vld,
  output logic              fq_rdy,
  input  logic              flush,
  output logic [7:0]        code,
  output logic              dc_vld,
  output logic [PH_W-1:0]   phase,
  output logic [31:0]       opnd,
  input  logic [N_UNIT-1:0] tb_mask,
  input  logic [1:0]        tb_mode,
  input  logic [PH_W-1:0]   tb_cnt,
  input  logic [N_UNIT-1:0] busy,
  output logic [N_UNIT-1:0] u_en,
  output logic              p_inc,
  output logic              stall
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    M_ONE  = 2'd0,
    M_STEP = 2'd1,
    M_WAIT = 2'd2,
    M_BUSY = 2'd3
  } mode_t;

  mode_t mode;
  assign mode = mode_t'(tb_mode);

  // Prefetch queue storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic [7:0]    head;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Sequencer decisions for this cycle
  logic            push;
  logic            pop;
  logic            load;
  logic            retire;
  logic            advance;
  logic            op_pop;
  logic            hold;
  logic            at_last;
  logic [PH_W-1:0] phase_inc;

  // State register: queue pointers, current instruction, phase, operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      code   <= '0;
      dc_vld <= 1'b0;
      phase  <= '0;
      opnd   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dc_vld <= 1'b0;
      phase  <= '0;
      opnd   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase

      if (load) begin
        code   <= head;
        dc_vld <= 1'b1;
        phase  <= '0;
        opnd   <= '0;
      end else if (retire) begin
        dc_vld <= 1'b0;
      end else if (advance) begin
        phase <= phase_inc;
        if (op_pop) opnd <= {opnd[23:0], head};
      end
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ram_d;
  end

  // Next-state decisions
  always_comb begin
    retire    = 1'b0;
    advance   = 1'b0;
    op_pop    = 1'b0;
    hold      = 1'b0;
    at_last   = (phase >= tb_cnt);
    // Saturate so the counter never wraps when tb_cnt is the maximum value
    phase_inc = (phase == '1) ? phase : phase + PH_W'(1);

    if (dc_en && !flush && dc_vld) begin
      if (tb_cnt == '0) begin
        retire = 1'b1;
      end else begin
        case (mode)
          M_ONE: retire = 1'b1;
          M_STEP: begin
            if (at_last)     retire = 1'b1;
            else if (!empty) begin
              advance = 1'b1;
              op_pop  = 1'b1;
            end else         hold = 1'b1;
          end
          M_WAIT: begin
            if (at_last) retire = 1'b1;
            else         advance = 1'b1;
          end
          M_BUSY: begin
            // Phase 0 issues; phase 1 waits for the masked busy lines
            if (phase == '0)                 advance = 1'b1;
            else if ((busy & tb_mask) != '0) hold = 1'b1;
            else                             retire = 1'b1;
          end
          default: ;
        endcase
      end
    end

    load = dc_en && !flush && (!dc_vld || retire) && !empty;
    pop  = load || op_pop;
    push = ram_vld && !full && !flush;
  end

  // Outputs
  always_comb begin
    fq_rdy = !full;
    u_en   = (dc_vld && dc_en) ? tb_mask : '0;
    p_inc  = pop;
    stall  = hold;
  end

endmodule
